// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Purpose  : Default sizing constants and depth helper shared by the FIFO.
// Revision : 1.0
// ============================================================================
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADD_WIDTH  = 3;

  function automatic int fifo_depth(input int add_width);
    return 1 << add_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mem
// Purpose  : FIFO storage array with one write port, a registered read port
//            and a synchronous clear of every entry and the read register.
// Revision : 1.0
// ============================================================================
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADD_WIDTH  = DEFAULT_ADD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADD_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADD_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADD_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The controller never enables both ports on the same address in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with wrap-bit pointers and registered read data.
//            Define SYNC_FIFO_COUNT_EN to add the data_count occupancy output.
// Revision : 1.0
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADD_WIDTH  = DEFAULT_ADD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [ADD_WIDTH:0]    data_count
`endif
);

  localparam logic [ADD_WIDTH:0] PTR_ONE = {{ADD_WIDTH{1'b0}}, 1'b1};

  logic [ADD_WIDTH:0] wr_ptr;
  logic [ADD_WIDTH:0] rd_ptr;
  logic               wr_accept;
  logic               rd_accept;

  // Equal low bits mean either empty or full; the wrap bit tells them apart.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[ADD_WIDTH] != rd_ptr[ADD_WIDTH]) &&
                      (wr_ptr[ADD_WIDTH-1:0] == rd_ptr[ADD_WIDTH-1:0]);

  assign wr_accept = wr_en && !fifo_full;
  assign rd_accept = rd_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef SYNC_FIFO_COUNT_EN
  assign data_count = wr_ptr - rd_ptr;
`endif

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADD_WIDTH  (ADD_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADD_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADD_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Directed self-checking bench for sync_fifo (8 x 8 default).
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
`ifdef SYNC_FIFO_COUNT_EN
  logic [3:0] data_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (8),
    .ADD_WIDTH  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .data_count (data_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] v;

    // Reset held 2 cycles with both requests active
    rst = 1'b1;
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("rst_idle_empty", fifo_empty, 1'b1);
`ifdef SYNC_FIFO_COUNT_EN
    chk("rst_count", data_count, 4'd0);
`endif

    // Fill 0x11..0x88
    for (int k = 1; k <= 8; k++) begin
      v = 8'(k * 'h11);
      step(1'b1, v, 1'b0);
      chk($sformatf("fill_empty_%0d", k), fifo_empty, 1'b0);
      chk($sformatf("fill_full_%0d", k), fifo_full, (k == 8) ? 1'b1 : 1'b0);
    end
`ifdef SYNC_FIFO_COUNT_EN
    chk("fill_count", data_count, 4'd8);
`endif
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_full", fifo_full, 1'b1);
    chk("ovf_dout", data_out, 8'h00);

    // Drain, then an underflow read holds data_out
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain_dout_%0d", k), data_out, 32'(k * 'h11));
      chk($sformatf("drain_full_%0d", k), fifo_full, 1'b0);
    end
    chk("drain_empty", fifo_empty, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_dout", data_out, 8'h88);
    chk("udf_empty", fifo_empty, 1'b1);

    // Wrap: 5 in/out, then a full cycle of 8 across the pointer wrap
    for (int k = 1; k <= 5; k++) step(1'b1, 8'(k), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap5_dout_%0d", k), data_out, 32'(k));
    end
    chk("wrap5_empty", fifo_empty, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hA0 + k), 1'b0);
    chk("wrap8_full", fifo_full, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap8_dout_%0d", k), data_out, 32'(8'hA0 + k));
    end
    chk("wrap8_empty", fifo_empty, 1'b1);
    chk("wrap8_notfull", fifo_full, 1'b0);

    // Simultaneous read/write with 3 entries held
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hB3, 1'b0);
    step(1'b1, 8'hC1, 1'b1);
    chk("sim_dout_0", data_out, 8'hB1);
    step(1'b1, 8'hC2, 1'b1);
    chk("sim_dout_1", data_out, 8'hB2);
    step(1'b1, 8'hC3, 1'b1);
    chk("sim_dout_2", data_out, 8'hB3);
    step(1'b1, 8'hC4, 1'b1);
    chk("sim_dout_3", data_out, 8'hC1);
    chk("sim_empty", fifo_empty, 1'b0);
    chk("sim_full", fifo_full, 1'b0);
`ifdef SYNC_FIFO_COUNT_EN
    chk("sim_count", data_count, 4'd3);
`endif
    step(1'b0, 8'h00, 1'b1);
    chk("sim_tail_0", data_out, 8'hC2);
    step(1'b0, 8'h00, 1'b1);
    chk("sim_tail_1", data_out, 8'hC3);
    step(1'b0, 8'h00, 1'b1);
    chk("sim_tail_2", data_out, 8'hC4);
    chk("sim_tail_empty", fifo_empty, 1'b1);

    // Simultaneous while empty: write only, data_out holds
    step(1'b1, 8'hD1, 1'b1);
    chk("sime_dout", data_out, 8'hC4);
    chk("sime_empty", fifo_empty, 1'b0);
    for (int k = 2; k <= 8; k++) step(1'b1, 8'(8'hD0 + k), 1'b0);
    chk("simf_full_pre", fifo_full, 1'b1);

    // Simultaneous while full: read only, 0xEE dropped
    step(1'b1, 8'hEE, 1'b1);
    chk("simf_dout", data_out, 8'hD1);
    chk("simf_full", fifo_full, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk($sformatf("simf_dout_%0d", k), data_out, 32'(8'hD0 + k));
    end
    chk("simf_empty", fifo_empty, 1'b1);

    // Reset mid-stream discards stored data
    for (int k = 1; k <= 4; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
    chk("mid_pre_empty", fifo_empty, 1'b0);
    rst = 1'b1;
    step(1'b1, 8'h99, 1'b1);
    rst = 1'b0;
    chk("mid_empty", fifo_empty, 1'b1);
    chk("mid_full", fifo_full, 1'b0);
    chk("mid_dout", data_out, 8'h00);
    step(1'b1, 8'h77, 1'b0);
    chk("mid_wr_empty", fifo_empty, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_rd_dout", data_out, 8'h77);
    chk("mid_rd_empty", fifo_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADD_WIDTH, default 3, address width; depth = 2**ADD_WIDTH (8 entries by default).
REQ-003 SHALL have one clock and the reset SHALL be synchronous, active-high.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port rd_en  input  1  read request.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port fifo_full  output  1  no free entry.
REQ-011 SHALL have port fifo_empty  output  1  no stored entry.

Function
REQ-012 SHALL keep write and read pointers of ADD_WIDTH+1 bits; the low ADD_WIDTH bits address memory, and the MSB is the wrap bit.
REQ-013 SHALL accept a write when wr_en=1 and fifo_full=0: mem[wr_addr] <= data_in; the write pointer increments by 1.
REQ-014 SHALL accept a read when rd_en=1 and fifo_empty=0: data_out <= mem[rd_addr] on that edge (1-cycle latency); the read pointer increments by 1.
REQ-015 SHALL ignore a write while full (no pointer or memory change) and a read while empty (pointer and data_out hold).
REQ-016 SHALL decode fifo_empty combinationally from registered pointers: asserted when the pointers are equal.
REQ-017 SHALL decode fifo_full combinationally from registered pointers: asserted when the MSBs differ and the low bits are equal.
REQ-018 SHALL wrap pointers modulo 2**(ADD_WIDTH+1) with no special case.
REQ-019 Simultaneous wr_en and rd_en, neither full nor empty: both SHALL occur and the occupancy SHALL be unchanged.
REQ-020 Simultaneous wr_en and rd_en while full: only the read SHALL occur and fifo_full SHALL deassert next cycle.
REQ-021 Simultaneous wr_en and rd_en while empty: only the write SHALL occur and fifo_empty SHALL deassert next cycle.
REQ-022 SHALL hold data_out when no read is accepted.

Reset
REQ-023 On clk edge with rst=1: both pointers SHALL be 0, data_out SHALL be 0, every memory entry SHALL be 0, fifo_empty=1 and fifo_full=0.
REQ-024 rst SHALL override wr_en and rd_en in the same cycle; reset mid-operation SHALL discard all stored data.

Configuration
REQ-025 With macro SYNC_FIFO_COUNT_EN defined, SHALL add output data_count [ADD_WIDTH:0], equal to wr_ptr minus rd_ptr (combinational, 0..2**ADD_WIDTH, 0 after reset).
REQ-026 Without SYNC_FIFO_COUNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package sync_fifo_pkg SHALL hold the default DATA_WIDTH/ADD_WIDTH constants and a helper for the depth (2**ADD_WIDTH).
REQ-028 Storage SHALL be one sub-module sync_fifo_mem, with a write port, registered read port and synchronous clear.
REQ-029 Pointer and flag logic SHALL reside in sync_fifo.

Verification
REQ-030 Reset: assert rst 2 cycles with wr_en=rd_en=1 -> fifo_empty=1, fifo_full=0, data_out=0, and no pointer movement.
REQ-031 Fill: write 0x11..0x88 (8 writes) -> fifo_full=1 after 8th edge; a 9th write of 0xFF is ignored, and a later read sequence returns 0x11..0x88 only.
REQ-032 Drain: from full, 8 reads -> data_out 0x11..0x88 each 1 cycle after rd_en; fifo_empty=1 after 8th; a 9th read keeps data_out=0x88.
REQ-033 Wrap: 5 writes, 5 reads, then 8 writes 0xA0..0xA7 and 8 reads -> order preserved across pointer wrap, and the full/empty flags are correct.
REQ-034 Simultaneous: with 3 entries held, assert wr_en+rd_en for 4 cycles -> occupancy stays 3 (data_count=3 when SYNC_FIFO_COUNT_EN is defined); when full, a simultaneous request drops the write; when empty, it drops the read.
REQ-035 Reset mid-stream: 4 writes, then rst for 1 cycle -> fifo_empty=1 and data_out=0; the next write/read pair returns the new data.
